// File: rtl/i2c_target.sv
// i2c_target: I2C target (slave) on a two-wire bus, oversampled on clk.
// Detects START, repeated START and STOP, and matches the TARGET_ADDR address.
// After a match it either receives write bytes or returns read bytes.
// Build option: define I2C_TARGET_FILTER_EN to add a 3-sample majority glitch
// filter on SCL and SDA after the synchronizer. Without it, any 1-clk pulse is an edge.
//
// Handshake semantics:
//   rx_valid is a one-cycle pulse with no backpressure. rx_data is new in that
//   cycle and holds its value until the next received byte.
//   tx_req is a one-cycle request with no backpressure. tx_data must be valid
//   in the same cycle and is captured combinationally into the shift register.
//   state_dbg mirrors the FSM state.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       busy,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_DATA  = 3'd3,
        WR_ACK   = 3'd4,
        RD_DATA  = 3'd5,
        RD_ACK   = 3'd6
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic       byte_full, byte_full_nxt;
    logic [7:0] shift, shift_nxt;
    logic       rw, rw_nxt;
    logic       mst_ack, mst_ack_nxt;
    logic       sda_low, sda_low_nxt;
    logic       busy_nxt;
    logic [7:0] rx_data_nxt;
    logic       rx_valid_nxt;

    logic scl_m, scl_s, sda_m, sda_s;
    logic scl_c, sda_c;
    logic scl_p, sda_p;
    logic scl_rise, scl_fall, start_det, stop_det;

    // Open-drain: only ever pull SDA low, otherwise release it.
    assign i2c_sda   = sda_low ? 1'b0 : 1'bz;
    assign state_dbg = state;

    // Two-flop synchronizer on both bus lines; idle bus level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_m <= 1'b1;
            scl_s <= 1'b1;
            sda_m <= 1'b1;
            sda_s <= 1'b1;
        end else begin
            scl_m <= i2c_scl;
            scl_s <= scl_m;
            sda_m <= i2c_sda;
            sda_s <= sda_m;
        end
    end

`ifdef I2C_TARGET_FILTER_EN
    logic [2:0] scl_h, sda_h;

    // Majority of the last three synced samples; a single-clk pulse never wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_h <= 3'b111;
            sda_h <= 3'b111;
            scl_c <= 1'b1;
            sda_c <= 1'b1;
        end else begin
            scl_h <= {scl_h[1:0], scl_s};
            sda_h <= {sda_h[1:0], sda_s};
            scl_c <= (scl_h[0] & scl_h[1]) | (scl_h[0] & scl_h[2]) | (scl_h[1] & scl_h[2]);
            sda_c <= (sda_h[0] & sda_h[1]) | (sda_h[0] & sda_h[2]) | (sda_h[1] & sda_h[2]);
        end
    end
`else
    assign scl_c = scl_s;
    assign sda_c = sda_s;
`endif

    // Previous-sample copies used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_p <= scl_c;
            sda_p <= sda_c;
        end
    end

    // START/STOP need SCL high in both samples, so a simultaneous SCL+SDA edge is a data bit.
    assign scl_rise  = ~scl_p & scl_c;
    assign scl_fall  = scl_p & ~scl_c;
    assign start_det = scl_p & scl_c & sda_p & ~sda_c;
    assign stop_det  = scl_p & scl_c & ~sda_p & sda_c;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= 3'd0;
            byte_full <= 1'b0;
            shift     <= 8'h00;
            rw        <= 1'b0;
            mst_ack   <= 1'b0;
            sda_low   <= 1'b0;
            busy      <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
        end else begin
            bit_cnt   <= bit_cnt_nxt;
            byte_full <= byte_full_nxt;
            shift     <= shift_nxt;
            rw        <= rw_nxt;
            mst_ack   <= mst_ack_nxt;
            sda_low   <= sda_low_nxt;
            busy      <= busy_nxt;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
        end
    end

    // Next-state and datapath decode; START/STOP override every state.
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        byte_full_nxt = byte_full;
        shift_nxt     = shift;
        rw_nxt        = rw;
        mst_ack_nxt   = mst_ack;
        sda_low_nxt   = sda_low;
        busy_nxt      = busy;
        rx_data_nxt   = rx_data;
        rx_valid_nxt  = 1'b0;
        tx_req        = 1'b0;

        if (start_det) begin
            state_nxt     = ADDR;
            bit_cnt_nxt   = 3'd0;
            byte_full_nxt = 1'b0;
            sda_low_nxt   = 1'b0;
        end else if (stop_det) begin
            state_nxt   = IDLE;
            sda_low_nxt = 1'b0;
            busy_nxt    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sda_low_nxt = 1'b0;
                end
                ADDR, WR_DATA: begin
                    if (scl_rise) begin
                        shift_nxt   = {shift[6:0], sda_c};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) byte_full_nxt = 1'b1;
                    end else if (scl_fall && byte_full) begin
                        byte_full_nxt = 1'b0;
                        if (state == ADDR) begin
                            if (shift[7:1] == TARGET_ADDR) begin
                                sda_low_nxt = 1'b1;
                                busy_nxt    = 1'b1;
                                rw_nxt      = shift[0];
                                state_nxt   = ADDR_ACK;
                            end else begin
                                sda_low_nxt = 1'b0;
                                busy_nxt    = 1'b0;
                                state_nxt   = IDLE;
                            end
                        end else begin
                            rx_data_nxt  = shift;
                            rx_valid_nxt = 1'b1;
                            sda_low_nxt  = 1'b1;
                            state_nxt    = WR_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_low_nxt = 1'b0;
                        bit_cnt_nxt = 3'd0;
                        if (!rw) begin
                            state_nxt = WR_DATA;
                        end else begin
                            tx_req      = 1'b1;
                            shift_nxt   = tx_data;
                            sda_low_nxt = ~tx_data[7];
                            state_nxt   = RD_DATA;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_low_nxt   = 1'b0;
                        bit_cnt_nxt   = 3'd0;
                        byte_full_nxt = 1'b0;
                        state_nxt     = WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_low_nxt = 1'b0;
                            bit_cnt_nxt = 3'd0;
                            mst_ack_nxt = 1'b0;
                            state_nxt   = RD_ACK;
                        end else begin
                            shift_nxt   = {shift[6:0], 1'b0};
                            sda_low_nxt = ~shift[6];
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_c) begin
                            busy_nxt  = 1'b0;
                            state_nxt = IDLE;
                        end else begin
                            mst_ack_nxt = 1'b1;
                        end
                    end else if (scl_fall && mst_ack) begin
                        tx_req      = 1'b1;
                        shift_nxt   = tx_data;
                        sda_low_nxt = ~tx_data[7];
                        bit_cnt_nxt = 3'd0;
                        mst_ack_nxt = 1'b0;
                        state_nxt   = RD_DATA;
                    end
                end
                default: begin
                    sda_low_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bus-master driver tasks, expected-value queues with monitor
// processes, and a final report for i2c_target.
module tb_i2c_target;

    localparam int Q = 8;   // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst;
    logic       m_scl;
    logic       m_sda_low;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;
    logic [2:0] state_dbg;
    wire        sda_bus;

    int total = 0;
    int bad   = 0;
    int tx_req_cnt = 0;

    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_rd_q[$];
    logic [0:0] exp_ack_q[$];

    event       ack_ev;
    event       rd_ev;
    logic       ack_s;
    logic [7:0] rd_s;

    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_target #(.TARGET_ADDR(7'h50)) dut (
        .clk      (clk),
        .rst      (rst),
        .i2c_scl  (m_scl),
        .i2c_sda  (sda_bus),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_req   (tx_req),
        .busy     (busy),
        .state_dbg(state_dbg)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected run to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rx_valid cycle pops one expected write byte.
    always @(negedge clk) begin
        if (rx_valid) begin
            total++;
            if (exp_rx_q.size() == 0) begin
                bad++;
                $display("FAIL rx_unexpected: got rx_data=%02h expected no rx_valid", rx_data);
            end else if (rx_data !== exp_rx_q[0]) begin
                bad++;
                $display("FAIL rx_data: got %02h expected %02h", rx_data, exp_rx_q[0]);
                void'(exp_rx_q.pop_front());
            end else begin
                void'(exp_rx_q.pop_front());
            end
        end
    end

    // Monitor: count read-byte requests.
    always @(negedge clk) begin
        if (tx_req) tx_req_cnt++;
    end

    // Monitor: ACK bit seen by the master on the 9th clock of a written byte.
    always @(ack_ev) begin
        total++;
        if (exp_ack_q.size() == 0) begin
            bad++;
            $display("FAIL ack_unexpected: got %0b expected no ack slot", ack_s);
        end else begin
            if (ack_s !== exp_ack_q[0]) begin
                bad++;
                $display("FAIL ack_bit: got %0b expected %0b", ack_s, exp_ack_q[0]);
            end
            void'(exp_ack_q.pop_front());
        end
    end

    // Monitor: byte shifted out by the target during a read.
    always @(rd_ev) begin
        total++;
        if (exp_rd_q.size() == 0) begin
            bad++;
            $display("FAIL rd_unexpected: got %02h expected no read byte", rd_s);
        end else begin
            if (rd_s !== exp_rd_q[0]) begin
                bad++;
                $display("FAIL rd_byte: got %02h expected %02h", rd_s, exp_rd_q[0]);
            end
            void'(exp_rd_q.pop_front());
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // START from idle or repeated START from SCL low.
    task automatic bus_start();
        m_sda_low = 1'b0;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        m_sda_low = 1'b1;
        wait_clk(Q);
        m_scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        m_sda_low = 1'b0;
        wait_clk(Q);
    endtask

    // glitch=1 inserts a one-clk SCL low pulse in the middle of the high phase.
    task automatic write_bit(input logic b, input logic glitch);
        m_sda_low = ~b;
        wait_clk(Q);
        m_scl = 1'b1;
        if (glitch) begin
            wait_clk(Q);
            m_scl = 1'b0;
            wait_clk(1);
            m_scl = 1'b1;
            wait_clk(Q - 1);
        end else begin
            wait_clk(2 * Q);
        end
        m_scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        b = sda_bus;
        wait_clk(Q);
        m_scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_ack, input int glitch_bit);
        logic a;
        exp_ack_q.push_back(exp_ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i], (i == glitch_bit));
        read_bit(a);
        ack_s = a;
        -> ack_ev;
    endtask

    // master_ack=1 answers ACK, 0 answers NACK; next_tx is presented before the ACK slot.
    task automatic read_byte(input logic [7:0] exp, input logic master_ack, input logic [7:0] next_tx);
        logic [7:0] r;
        logic       b;
        exp_rd_q.push_back(exp);
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            r[i] = b;
        end
        rd_s = r;
        -> rd_ev;
        tx_data = next_tx;
        write_bit(~master_ack, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        m_scl     = 1'b1;
        m_sda_low = 1'b0;
        tx_data   = 8'h00;
        wait_clk(4);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_tx_req", tx_req, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_state", state_dbg, 3'd0);
        check("reset_sda", sda_bus, 1'b1);
        rst = 1'b0;
        wait_clk(4);

        // Addressed write of 0xA5 then STOP.
        exp_rx_q.push_back(8'hA5);
        bus_start();
        write_byte(8'hA0, 1'b0, -1);
        write_byte(8'hA5, 1'b0, -1);
        check("wr_busy_before_stop", busy, 1'b1);
        bus_stop();
        wait_clk(4);
        check("wr_busy_after_stop", busy, 1'b0);
        check("wr_state_after_stop", state_dbg, 3'd0);

        // Wrong address 0x51: NACK and back to IDLE.
        bus_start();
        write_byte(8'hA2, 1'b1, -1);
        check("nack_state", state_dbg, 3'd0);
        check("nack_busy", busy, 1'b0);
        bus_stop();
        wait_clk(4);

        // Single-byte read 0x3C, master NACKs.
        tx_data = 8'h3C;
        bus_start();
        write_byte(8'hA1, 1'b0, -1);
        read_byte(8'h3C, 1'b0, 8'h00);
        check("rd1_state", state_dbg, 3'd0);
        check("rd1_sda_released", sda_bus, 1'b1);
        check("rd1_busy", busy, 1'b0);
        check("rd1_tx_req_cnt", tx_req_cnt, 1);
        bus_stop();
        wait_clk(4);

        // Two-byte read with master ACK between bytes.
        tx_data = 8'h3C;
        bus_start();
        write_byte(8'hA1, 1'b0, -1);
        read_byte(8'h3C, 1'b1, 8'hC3);
        read_byte(8'hC3, 1'b0, 8'h00);
        check("rd2_tx_req_cnt", tx_req_cnt, 3);
        bus_stop();
        wait_clk(4);

        // Write 0x11, repeated START, then read 0x5A.
        exp_rx_q.push_back(8'h11);
        bus_start();
        write_byte(8'hA0, 1'b0, -1);
        write_byte(8'h11, 1'b0, -1);
        check("rs_busy_before", busy, 1'b1);
        bus_start();
        check("rs_busy_after", busy, 1'b1);
        check("rs_state_addr", state_dbg, 3'd1);
        tx_data = 8'h5A;
        write_byte(8'hA1, 1'b0, -1);
        read_byte(8'h5A, 1'b0, 8'h00);
        bus_stop();
        wait_clk(4);
        check("rs_rx_data", rx_data, 8'h11);
        check("rs_tx_req_cnt", tx_req_cnt, 4);
        check("rs_busy_end", busy, 1'b0);

        // Reset in the middle of a read while the target holds SDA low.
        tx_data = 8'h00;
        bus_start();
        write_byte(8'hA1, 1'b0, -1);
        wait_clk(2);
        check("rr_sda_driven_low", sda_bus, 1'b0);
        check("rr_state_rd", state_dbg, 3'd5);
        check("rr_tx_req_cnt", tx_req_cnt, 5);
        #2;
        rst = 1'b1;
        #1;
        check("rr_sda_released", sda_bus, 1'b1);
        check("rr_busy", busy, 1'b0);
        check("rr_state", state_dbg, 3'd0);
        check("rr_rx_data", rx_data, 8'h00);
        check("rr_tx_req", tx_req, 1'b0);
        check("rr_rx_valid", rx_valid, 1'b0);
        m_scl = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(8);

`ifdef I2C_TARGET_FILTER_EN
        // One-clk SCL low glitch inside bit 4 of the data byte.
        exp_rx_q.push_back(8'h96);
        bus_start();
        write_byte(8'hA0, 1'b0, -1);
        write_byte(8'h96, 1'b0, 4);
        bus_stop();
        wait_clk(4);
        check("flt_rx_data", rx_data, 8'h96);
`endif

        wait_clk(10);
        check("rx_queue_drained", exp_rx_q.size(), 0);
        check("rd_queue_drained", exp_rd_q.size(), 0);
        check("ack_queue_drained", exp_ack_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
